keypad_input: RTL and testbench
===============================

Name: keypad_input

Overview:
Debounces the eight active-low board buttons and produces the `keypad` vector that drives the `key` input of the `boy` core. The block is a direct upstream stage of `boy`. It synchronises the raw pins and filters each bit over a shared millisecond-scale tick. It also emits a one-cycle `rst_req` pulse when the A+B+Select+Start combo is held long enough; `top` ORs this pulse into its reset-delay logic.

Parameters:
TICK_DIV, 12000, clk cycles per debounce tick (1 kHz at 12 MHz); must be ≥2
DEBOUNCE_TICKS, 10, consecutive ticks a bit must disagree with its debounced value before it flips; must be ≥1
COMBO_TICKS, 2000, ticks the full A+B+Select+Start combo must be held before `rst_req` fires; must be ≥1

Ports:
clk  input  1  board clock (same domain as the rst_delay logic in top)
rst  input  1  synchronous, active-high reset
btn_n  input  8  raw buttons, active-low, asynchronous; bit map same as key
key  output  8  debounced, active-high; [0]=right [1]=left [2]=up [3]=down [4]=A [5]=B [6]=select [7]=start
key_changed  output  1  one-cycle pulse when `key` differs from its previous value
rst_req  output  1  one-cycle pulse when the reset combo completes

Behaviour:
Reset (rst=1 at a clk edge):
- key=0, key_changed=0, rst_req=0.
- Sync flops = 8'hFF (released).
- Debounced state = 0; per-bit counters = 0; prescaler = 0.
- Combo FSM = IDLE; combo counter = 0.
- A button held through reset is re-debounced from scratch. The full latency applies again.

Synchroniser:
- Two-flop synchroniser per bit on btn_n.
- Inverted synchroniser output is `raw[7:0]`.

Prescaler and tick:
- Counter runs 0..TICK_DIV-1, then wraps to 0.
- `tick` is high for the one cycle in which the count equals TICK_DIV-1.

Per-bit debounce:
- If raw[i]==db[i], cnt[i] clears to 0 on every cycle, tick or not.
- Else, on tick:
  - if cnt[i]==DEBOUNCE_TICKS-1: db[i] toggles and cnt[i] clears to 0;
  - otherwise cnt[i] increments.
- cnt[i] width is clog2(DEBOUNCE_TICKS), minimum 1 bit. cnt[i] never wraps.

Output stage:
- key <= filtered(db), one register stage.
- key_changed <= (filtered(db) != key), registered in the same cycle as key.
- Latency from a btn_n edge to key changing is 2 (sync) + between (DEBOUNCE_TICKS-1)*TICK_DIV+1 and DEBOUNCE_TICKS*TICK_DIV cycles (debounce) + 1 (output register).

Combo FSM:
- `combo` = (db[7:4]==4'hF), taken from db before any filtering.
- IDLE: if combo, go to COUNT with counter=0.
- COUNT:
  - if !combo, go to IDLE;
  - else on tick: if counter==COMBO_TICKS-1, go to FIRE; otherwise counter++.
- FIRE: rst_req=1 for exactly this one cycle; go to WAIT_REL.
- WAIT_REL: stay until !combo, then go to IDLE. This gives no repeat pulse while the combo stays held.
- rst_req is registered (high only in FIRE) and low in every other state.
- If the combo is released and the tick occur in the same cycle, release wins and the FSM goes to IDLE.

Optional Feature:
Macro KEY_SOCD_EN selects the `filtered()` function applied in the output stage.

Defined (SOCD cleaning):
- db[0]&db[1] forces key[1:0]=0.
- db[2]&db[3] forces key[3:2]=0.
- All other bits pass through unchanged.
- key_changed reflects the post-filter value.
- The combo FSM still uses unfiltered db.

Undefined: filtered(db)=db. No extra logic is generated.

Test Plan:
Parameters for all scenarios: TICK_DIV=4, DEBOUNCE_TICKS=3, COMBO_TICKS=5.
1. Reset, btn_n=8'hFF → key=8'h00, key_changed=0 and rst_req=0 for 100 cycles.
2. btn_n[4] driven low and held → key becomes 8'h10 between cycles 12 and 15 after the edge, with a single key_changed pulse. On release, key returns to 8'h00 within the same window, with one more pulse.
3. btn_n[5] low for 6 cycles, then high; repeated bursts each shorter than 2 ticks → key stays 8'h00 and key_changed never pulses.
4. btn_n=8'h0F held → key=8'hF0. rst_req pulses exactly once, 5 ticks (±1 tick) after key reaches F0, and stays low while the combo remains held. Release btn_n[7] briefly and re-press it → a second rst_req pulse follows after another 5 ticks. Release btn_n[7] for 3 ticks in the middle of the count → FSM returns to IDLE and no pulse occurs.
5. Button held, then rst asserted for 1 cycle → key=0 the next cycle, then key re-asserts after the full debounce window.
6. btn_n[1:0]=2'b00 (left+right) → with KEY_SOCD_EN, key[1:0]=00; without it, key[1:0]=11. Release left → key[1:0]=01 in both builds.

Source files
------------

// File: rtl/keypad_input.sv
// keypad_input: two-flop synchroniser, tick-based per-button debounce and a held A+B+Select+Start reset-request detector.
// Optional macro KEY_SOCD_EN clears opposing direction pairs (left+right, up+down) on the key output.
module keypad_db_bit #(
  parameter int DEBOUNCE_TICKS = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  input  logic i_tick,
  output logic o_db
);
  localparam int CW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_db;

  // Any cycle of agreement restarts the run; only ticks of continuous disagreement count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_db  <= 1'b0;
      r_cnt <= '0;
    end else if (i_raw == r_db) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      if (r_cnt == CW'(DEBOUNCE_TICKS - 1)) begin
        r_db  <= ~r_db;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_db = r_db;
endmodule

module keypad_input #(
  parameter int TICK_DIV       = 12000,
  parameter int DEBOUNCE_TICKS = 10,
  parameter int COMBO_TICKS    = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] btn_n,
  output logic [7:0] key,
  output logic       key_changed,
  output logic       rst_req
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int KW = (COMBO_TICKS > 1) ? $clog2(COMBO_TICKS) : 1;

  typedef enum logic [1:0] {IDLE, COUNT, FIRE, WAIT_REL} combo_st_t;

  logic [7:0]    r_sync1, r_sync2;
  logic [PW-1:0] r_pre;
  logic [7:0]    r_key;
  logic          r_kc;
  combo_st_t     r_st;
  logic [KW-1:0] r_ccnt;
  logic          r_rst_req;
  logic [7:0]    w_raw, w_db, w_filt;
  logic          w_tick, w_combo;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 8'hFF;
      r_sync2 <= 8'hFF;
    end else begin
      r_sync1 <= btn_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_raw  = ~r_sync2;
  assign w_tick = (r_pre == PW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || w_tick) r_pre <= '0;
    else               r_pre <= r_pre + 1'b1;
  end

  keypad_db_bit #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db [7:0] (
    .clk    (clk),
    .rst    (rst),
    .i_raw  (w_raw),
    .i_tick (w_tick),
    .o_db   (w_db)
  );

`ifdef KEY_SOCD_EN
  always_comb begin
    w_filt = w_db;
    if (w_db[0] & w_db[1]) w_filt[1:0] = 2'b00;
    if (w_db[2] & w_db[3]) w_filt[3:2] = 2'b00;
  end
`else
  assign w_filt = w_db;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_key <= 8'h00;
      r_kc  <= 1'b0;
    end else begin
      r_key <= w_filt;
      r_kc  <= (w_filt != r_key);
    end
  end

  // Combo uses the unfiltered debounced state so SOCD cleaning can never mask it.
  assign w_combo = (w_db[7:4] == 4'hF);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st      <= IDLE;
      r_ccnt    <= '0;
      r_rst_req <= 1'b0;
    end else begin
      r_rst_req <= 1'b0;
      case (r_st)
        IDLE: if (w_combo) begin
          r_st   <= COUNT;
          r_ccnt <= '0;
        end
        COUNT: begin
          if (!w_combo) begin
            r_st <= IDLE;
          end else if (w_tick) begin
            if (r_ccnt == KW'(COMBO_TICKS - 1)) begin
              r_st      <= FIRE;
              r_rst_req <= 1'b1;
            end else begin
              r_ccnt <= r_ccnt + 1'b1;
            end
          end
        end
        FIRE:     r_st <= WAIT_REL;
        WAIT_REL: if (!w_combo) r_st <= IDLE;
        default:  r_st <= IDLE;
      endcase
    end
  end

  assign key         = r_key;
  assign key_changed = r_kc;
  assign rst_req     = r_rst_req;
endmodule

// File: tb/tb_keypad_input.sv
// Randomized + directed bench for keypad_input, checked every cycle against a time-based reference model.
module tb_keypad_input;
  localparam int TD = 4;
  localparam int DB = 3;
  localparam int CT = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] btn_n = 8'hFF;
  logic [7:0] key;
  logic       key_changed, rst_req;

  keypad_input #(.TICK_DIV(TD), .DEBOUNCE_TICKS(DB), .COMBO_TICKS(CT)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_n       (btn_n),
    .key         (key),
    .key_changed (key_changed),
    .rst_req     (rst_req)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: edges counted from reset release, ticks derived arithmetically.
  int         c, ph, cst, m_pulses, d_pulses;
  int         rs[8];
  logic [7:0] m_db, m_key;
  logic       m_kc, m_rr;
  logic [7:0] bh[$];

  function automatic logic [7:0] filt(input logic [7:0] d);
    logic [7:0] f;
    f = d;
`ifdef KEY_SOCD_EN
    if (d[0] && d[1]) f[1:0] = 2'b00;
    if (d[2] && d[3]) f[3:2] = 2'b00;
`endif
    return f;
  endfunction

  // number of tick edges e in [a,b], where edge e ticks when e%TD == TD-1
  function automatic int nt(input int a, input int b);
    return (b + 1) / TD - a / TD;
  endfunction

  task automatic model_edge();
    logic [7:0] raw, dbo;
    logic       tk, cb;
    if (rst) begin
      c = 0; ph = 0; cst = 0;
      m_db = 8'h00; m_key = 8'h00; m_kc = 1'b0; m_rr = 1'b0;
      for (int i = 0; i < 8; i++) rs[i] = -1;
      bh.delete();
      return;
    end
    bh.push_back(btn_n);
    if (bh.size() > 3) void'(bh.pop_front());
    raw = (bh.size() == 3) ? ~bh[0] : 8'h00;
    dbo = m_db;
    tk  = (c % TD) == TD - 1;
    cb  = (dbo[7:4] == 4'hF);
    m_kc  = (filt(dbo) != m_key);
    m_key = filt(dbo);
    // a bit flips on the DB-th tick of an unbroken run of disagreement
    for (int i = 0; i < 8; i++) begin
      if (raw[i] == dbo[i]) rs[i] = -1;
      else begin
        if (rs[i] < 0) rs[i] = c;
        if (tk && nt(rs[i], c) >= DB) begin
          m_db[i] = ~dbo[i];
          rs[i] = -1;
        end
      end
    end
    // pulse on the CT-th tick strictly after the combo was first seen; re-arm only after release
    m_rr = 1'b0;
    case (ph)
      0: if (cb) begin ph = 1; cst = c; end
      1: if (!cb) ph = 0;
         else if (tk && nt(cst + 1, c) >= CT) begin ph = 2; m_rr = 1'b1; m_pulses++; end
      2: ph = 3;
      default: if (!cb) ph = 0;
    endcase
    c++;
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      #1;
      if (rst_req === 1'b1) d_pulses++;
      chk("key", key, m_key);
      chk("key_changed", {7'b0, key_changed}, {7'b0, m_kc});
      chk("rst_req", {7'b0, rst_req}, {7'b0, m_rr});
    end
  endtask

  initial begin
    m_pulses = 0;
    d_pulses = 0;
    // 1: reset and idle
    rst = 1'b1; btn_n = 8'hFF;
    step(3);
    rst = 1'b0;
    step(100);
    // 2: press and release A
    btn_n = 8'hEF; step(25);
    chk("A_pressed", key, 8'h10);
    btn_n = 8'hFF; step(25);
    chk("A_released", key, 8'h00);
    // 3: short B bursts must be filtered out
    for (int r = 0; r < 6; r++) begin
      btn_n = 8'hDF; step(6);
      btn_n = 8'hFF; step(4 + r % 2);
    end
    chk("B_glitch", key, 8'h00);
    step(20);
    // 4: combo held, brief start release, mid-count release
    btn_n = 8'h0F; step(80);
    chk("combo_key", key, 8'hF0);
    btn_n = 8'h8F; step(20);
    btn_n = 8'h0F; step(60);
    btn_n = 8'hFF; step(25);
    btn_n = 8'h0F; step(18);
    btn_n = 8'h8F; step(12);
    btn_n = 8'h0F; step(60);
    btn_n = 8'hFF; step(30);
    // 5: reset while a button is held
    btn_n = 8'hEF; step(25);
    rst = 1'b1; step(1);
    rst = 1'b0; step(1);
    chk("after_rst", key, 8'h00);
    step(25);
    // 6: left+right, then release left
    btn_n = 8'hFC; step(25);
    btn_n = 8'hFE; step(25);
    chk("socd_right", {6'b0, key[1:0]}, 8'h01);
    btn_n = 8'hFF; step(25);
    // random segments, biased toward combos and short glitches
    for (int s = 0; s < 120; s++) begin
      case ($urandom_range(0, 4))
        0: btn_n = 8'($urandom);
        1: btn_n = {4'h0, 4'($urandom)};
        2: btn_n = 8'hFF;
        3: btn_n = btn_n ^ (8'h01 << $urandom_range(0, 7));
        default: btn_n = {1'($urandom), 3'h0, 4'hF};
      endcase
      if ($urandom_range(0, 40) == 0) begin
        rst = 1'b1; step(1); rst = 1'b0;
      end
      step(($urandom_range(0, 3) == 0) ? $urandom_range(40, 90) : $urandom_range(1, 20));
    end
    chk("pulse_count", 8'(d_pulses), 8'(m_pulses));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
